// File: rtl/sample_net_pipe_if.sv
// Valid/ready bundle for the sample_net_pipe operand and result streams.
// master drives operands and out_ready; slave is the pipe.
interface sample_net_pipe_if #(
    parameter int W = 8
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] c;
    logic [W-1:0] d;
    logic [W-1:0] e;
    logic [W-1:0] f;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] o;
    logic [W-1:0] p;
    logic [W-1:0] q;

    modport master (
        output in_valid, a, b, c, d, e, f, out_ready,
        input  in_ready, out_valid, o, p, q
    );

    modport slave (
        input  in_valid, a, b, c, d, e, f, out_ready,
        output in_ready, out_valid, o, p, q
    );
endinterface

// File: rtl/sample_net_pipe.sv
// Two-stage elastic, W-lane bit-sliced g..q logic net with
// a saturating activity counter on o and a sticky check on q.
module sample_net_pipe #(
    parameter int W     = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             ret,
    sample_net_pipe_if.slave bus,
    input  logic             clr_cnt,
    output logic [CNT_W-1:0] o_cnt,
    output logic             q_err
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic         s1_v;
    logic         s2_v;
    logic [W-1:0] g_r;
    logic [W-1:0] h_r;
    logic [W-1:0] i_r;
    logic [W-1:0] j_r;
    logic [W-1:0] b_r;
    logic [W-1:0] o_r;
    logic [W-1:0] p_r;
    logic [W-1:0] q_r;

    logic         s1_load;
    logic         s2_load;
    logic         xfer;
    logic [W-1:0] k;
    logic [W-1:0] l;
    logic [W-1:0] m;
    logic [W-1:0] n;

    assign s2_load = ~s2_v | bus.out_ready;
    assign s1_load = ~s1_v | s2_load;
    assign xfer    = s2_v & bus.out_ready;

    assign bus.in_ready  = ~s1_v | ~s2_v | bus.out_ready;
    assign bus.out_valid = s2_v;
    assign bus.o         = o_r;
    assign bus.p         = p_r;
    assign bus.q         = q_r;

    always_comb begin
        k = g_r | h_r | i_r;
        l = h_r & i_r & j_r;
        m = i_r & j_r;
        n = l & m;
    end

    // Operand regs only load on a real beat so idle X never enters.
    always_ff @(posedge clk) begin
        if (ret) begin
            s1_v <= 1'b0;
            g_r  <= '0;
            h_r  <= '0;
            i_r  <= '0;
            j_r  <= '0;
            b_r  <= '0;
        end else if (s1_load) begin
            s1_v <= bus.in_valid;
            if (bus.in_valid) begin
                g_r <= bus.a | bus.d;
                h_r <= ~bus.a & bus.c;
                i_r <= ~bus.c;
                j_r <= bus.d | bus.e | bus.f;
                b_r <= bus.b;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (ret) begin
            s2_v <= 1'b0;
            o_r  <= '0;
            p_r  <= '0;
            q_r  <= '0;
        end else if (s2_load) begin
            s2_v <= s1_v;
            if (s1_v) begin
                o_r <= b_r & h_r & k;
                p_r <= ~g_r;
                q_r <= ~n;
            end
        end
    end

    // Clear has priority over a coincident counted transfer.
    always_ff @(posedge clk) begin
        if (ret) begin
            o_cnt <= '0;
        end else if (clr_cnt) begin
            o_cnt <= '0;
        end else if (xfer && (|o_r) && (o_cnt != CNT_MAX)) begin
            o_cnt <= o_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (ret) begin
            q_err <= 1'b0;
        end else if (xfer && !(&q_r)) begin
            q_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_sample_net_pipe.sv
// Directed bench for sample_net_pipe with an in-bench queue model
// checked every cycle, plus literal expectations per scenario.
module tb_sample_net_pipe;
    localparam int W = 8;

    logic        clk = 1'b0;
    logic        ret = 1'b1;
    logic        clr_cnt = 1'b0;
    logic [15:0] o_cnt;
    logic        q_err;
    logic        clr_cnt1 = 1'b0;
    logic [3:0]  o_cnt1;
    logic        q_err1;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    sample_net_pipe_if #(.W(W)) bus0 ();
    sample_net_pipe_if #(.W(W)) bus1 ();

    sample_net_pipe #(.W(W), .CNT_W(16)) dut (
        .clk(clk), .ret(ret), .bus(bus0.slave),
        .clr_cnt(clr_cnt), .o_cnt(o_cnt), .q_err(q_err)
    );

    sample_net_pipe #(.W(W), .CNT_W(4)) dut_sat (
        .clk(clk), .ret(ret), .bus(bus1.slave),
        .clr_cnt(clr_cnt1), .o_cnt(o_cnt1), .q_err(q_err1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [W-1:0] o;
        logic [W-1:0] p;
        logic [W-1:0] q;
    } res_t;

    res_t        exp_q[$];
    logic [15:0] cnt_m  = '0;
    bit          qerr_m = 1'b0;

    // Closed-form net: h&i is always 0, so q is all ones and o = b&~a&c.
    function automatic res_t net(input logic [W-1:0] a, b, c, d);
        res_t r;
        r.o = b & ~a & c;
        r.p = ~(a | d);
        r.q = '1;
        return r;
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            chk("in_ready", 32'(bus0.in_ready),
                32'((exp_q.size() < 2) || bus0.out_ready));
            chk("o_cnt", 32'(o_cnt), 32'(cnt_m));
            chk("q_err", 32'(q_err), 32'(qerr_m));
            if (bus0.out_valid) begin
                if (exp_q.size() == 0) begin
                    chk("out_valid_empty", 32'(bus0.out_valid), 32'd0);
                end else begin
                    chk("o", 32'(bus0.o), 32'(exp_q[0].o));
                    chk("p", 32'(bus0.p), 32'(exp_q[0].p));
                    chk("q", 32'(bus0.q), 32'(exp_q[0].q));
                end
            end
        end
        if (ret) begin
            exp_q.delete();
            cnt_m  = '0;
            qerr_m = 1'b0;
        end else begin
            if (bus0.out_valid && bus0.out_ready && exp_q.size() > 0) begin
                if (clr_cnt) cnt_m = '0;
                else if (exp_q[0].o != 0 && cnt_m != 16'hFFFF) cnt_m = cnt_m + 1;
                if (exp_q[0].q != '1) qerr_m = 1'b1;
                void'(exp_q.pop_front());
            end else if (clr_cnt) begin
                cnt_m = '0;
            end
            if (bus0.in_valid && bus0.in_ready)
                exp_q.push_back(net(bus0.a, bus0.b, bus0.c, bus0.d));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle0();
        bus0.in_valid = 1'b0;
        bus0.a = 'x; bus0.b = 'x; bus0.c = 'x;
        bus0.d = 'x; bus0.e = 'x; bus0.f = 'x;
    endtask

    task automatic beat0(input logic [W-1:0] a, b, c, d, e, f);
        bus0.in_valid = 1'b1;
        bus0.a = a; bus0.b = b; bus0.c = c;
        bus0.d = d; bus0.e = e; bus0.f = f;
    endtask

    initial begin
        idle0();
        bus0.out_ready = 1'b1;
        bus1.in_valid  = 1'b0;
        bus1.out_ready = 1'b1;
        bus1.a = 8'h00; bus1.b = 8'hFF; bus1.c = 8'hFF;
        bus1.d = 8'h00; bus1.e = 8'h00; bus1.f = 8'h00;

        // Reset held two cycles with a beat offered
        beat0(8'h00, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00);
        step();
        step();
        chk("rst_out_valid", 32'(bus0.out_valid), 32'd0);
        chk("rst_o_cnt", 32'(o_cnt), 32'd0);
        chk("rst_q_err", 32'(q_err), 32'd0);
        chk("rst_o", 32'(bus0.o), 32'd0);
        ret = 1'b0;
        idle0();
        chk("rst_in_ready", 32'(bus0.in_ready), 32'd1);
        chk_en = 1'b1;

        // Single beat, two-cycle latency
        step();
        beat0(8'h00, 8'hFF, 8'h0F, 8'h00, 8'h00, 8'h00);
        step();
        idle0();
        chk("lat_not_yet", 32'(bus0.out_valid), 32'd0);
        step();
        chk("single_valid", 32'(bus0.out_valid), 32'd1);
        chk("single_o", 32'(bus0.o), 32'h0F);
        chk("single_p", 32'(bus0.p), 32'hFF);
        chk("single_q", 32'(bus0.q), 32'hFF);
        step();
        chk("single_cnt", 32'(o_cnt), 32'd1);

        // Backpressure: three beats offered, two held
        bus0.out_ready = 1'b0;
        beat0(8'h00, 8'hFF, 8'hF0, 8'h03, 8'h01, 8'h00);
        step();
        beat0(8'h0F, 8'h3C, 8'hFF, 8'h00, 8'h00, 8'h00);
        step();
        beat0(8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h80);
        chk("bp_in_ready", 32'(bus0.in_ready), 32'd0);
        chk("bp_valid", 32'(bus0.out_valid), 32'd1);
        chk("bp_o_a", 32'(bus0.o), 32'hF0);
        chk("bp_p_a", 32'(bus0.p), 32'hFC);
        step();
        step();
        chk("bp_hold_o", 32'(bus0.o), 32'hF0);
        chk("bp_hold_ready", 32'(bus0.in_ready), 32'd0);
        bus0.out_ready = 1'b1;
        chk("drain_a_valid", 32'(bus0.out_valid), 32'd1);
        step();
        idle0();
        chk("drain_b_valid", 32'(bus0.out_valid), 32'd1);
        chk("drain_b_o", 32'(bus0.o), 32'h30);
        chk("drain_b_p", 32'(bus0.p), 32'hF0);
        step();
        chk("drain_c_valid", 32'(bus0.out_valid), 32'd1);
        chk("drain_c_o", 32'(bus0.o), 32'h00);
        chk("drain_c_p", 32'(bus0.p), 32'h00);
        step();
        chk("drain_empty", 32'(bus0.out_valid), 32'd0);
        chk("drain_cnt", 32'(o_cnt), 32'd3);

        // Saturation on the 4-bit counter instance
        bus1.in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
        end
        bus1.in_valid = 1'b0;
        chk("sat_o", 32'(bus1.o), 32'hFF);
        for (int i = 0; i < 3; i++) begin
            step();
        end
        chk("sat_cnt", 32'(o_cnt1), 32'd15);
        chk("sat_q_err", 32'(q_err1), 32'd0);

        // Clear coincident with a counted transfer
        beat0(8'h00, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00);
        step();
        idle0();
        step();
        chk("clr_pre_valid", 32'(bus0.out_valid), 32'd1);
        clr_cnt = 1'b1;
        step();
        clr_cnt = 1'b0;
        chk("clr_cnt", 32'(o_cnt), 32'd0);
        chk("clr_q_err", 32'(q_err), 32'd0);

        // Reset with two beats in flight
        bus0.out_ready = 1'b0;
        beat0(8'h00, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00);
        step();
        beat0(8'h00, 8'hFF, 8'h0F, 8'h00, 8'h00, 8'h00);
        step();
        idle0();
        chk("flight_valid", 32'(bus0.out_valid), 32'd1);
        ret = 1'b1;
        step();
        chk("flush_valid", 32'(bus0.out_valid), 32'd0);
        chk("flush_o", 32'(bus0.o), 32'd0);
        ret = 1'b0;
        bus0.out_ready = 1'b1;
        chk("flush_in_ready", 32'(bus0.in_ready), 32'd1);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("no_stale", 32'(bus0.out_valid), 32'd0);
        end
        chk("flush_cnt", 32'(o_cnt), 32'd0);

        step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
